convolution: RTL and testbench
==============================

CONVOLUTION -- requirements
Module: convolution

Interface
REQ-001 The block SHALL have the parameter K_SELECT, default 1, which selects the kernel: 0 identity, 1 Gaussian, 2 sharpen.
REQ-002 The block SHALL have the port clk_in, input, 1 bit: the single clock.
REQ-003 The block SHALL have the port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port data_in, input, [2:0][15:0]: one RGB565 column from the line buffer; [0] is the top row, [1] the centre row, [2] the bottom row.
REQ-005 The block SHALL have the port data_valid_in, input, 1 bit: data_in, hcount_in and vcount_in are valid this cycle.
REQ-006 The block SHALL have the port hcount_in, input, 11 bits: column coordinate of data_in.
REQ-007 The block SHALL have the port vcount_in, input, 10 bits: row coordinate of data_in.
REQ-008 The block SHALL have the port line_out, output, 16 bits: filtered RGB565 pixel.
REQ-009 The block SHALL have the port data_valid_out, output, 1 bit: line_out, hcount_out and vcount_out are valid.
REQ-010 The block SHALL have the port hcount_out, output, 11 bits: hcount_in of the newest window column, delayed.
REQ-011 The block SHALL have the port vcount_out, output, 10 bits: vcount_in, delayed.

Function
REQ-012 The block SHALL hold a 3x3 window as three column registers: col0 oldest, col1 centre, col2 newest.
REQ-013 The window SHALL shift (col0<=col1, col1<=col2, col2<=data_in) only on cycles with data_valid_in=1; invalid cycles leave the window unchanged.
REQ-014 Left-edge clamp: on a valid input with hcount_in==0, col0, col1 and col2 SHALL all load data_in (replication).
REQ-015 The right edge SHALL receive no special handling; the last column of a row is never the window centre.
REQ-016 The pipeline SHALL be 3 stages: window register, per-channel weighted sum register, then shift/clamp/pack output register.
REQ-017 Latency: a valid input sampled at edge N SHALL produce data_valid_out=1 after edge N+2, i.e. exactly 3 cycles.
REQ-018 Gaps in data_valid_in SHALL propagate as bubbles and SHALL NOT alter output values.
REQ-019 hcount and vcount SHALL travel through a 3-deep pipeline in lockstep with valid; hcount_out is untranslated, so the window centre is at hcount_out-1, except at hcount_out==0 (replicated window).
REQ-020 Channels SHALL be unpacked as R=[15:11] (5 bits), G=[10:5] (6 bits) and B=[4:0] (5 bits), and processed independently.
REQ-021 Kernel 0 (identity) SHALL output the col1 centre pixel unchanged.
REQ-022 Kernel 1 (Gaussian) SHALL use weights 1 2 1 / 2 4 2 / 1 2 1, then a logical shift right by 4 (truncate).
REQ-023 Kernel 2 (sharpen) SHALL use weights 0 -1 0 / -1 5 -1 / 0 -1 0 with no shift.
REQ-024 Sums SHALL be 12-bit signed; after the shift, values <0 SHALL clamp to 0 and values above the channel max (31 or 63) SHALL clamp to that max.
REQ-025 The output SHALL be repacked as {R,G,B}; line_out, hcount_out and vcount_out hold their last values while data_valid_out=0.
REQ-026 An unsupported K_SELECT value SHALL behave as identity.

Reset
REQ-027 While rst_in=1 at a clock edge, line_out, hcount_out, vcount_out, data_valid_out, all window registers and all pipeline valid/coordinate registers SHALL become 0.
REQ-028 A reset asserted mid-stream SHALL discard all in-flight samples; no data_valid_out pulse from pre-reset inputs may appear after release.
REQ-029 The first valid input after reset SHALL produce data_valid_out 3 cycles later.

Verification
REQ-030 Constant 16'h0ABC on all rows, K_SELECT=1, 10x10 frame -> every output line_out=16'h0ABC, and data_valid_out count equals valid input count.
REQ-031 K_SELECT=0, linearly increasing pixels -> line_out equals the centre-row pixel of the previous valid column (the same column at hcount 0), 3 cycles after its input.
REQ-032 K_SELECT=2, centre pixel 16'hFFFF with all neighbours 0 -> 16'hFFFF (clamp high); centre 0 with the four orthogonal neighbours 16'hFFFF -> 16'h0000 (clamp low).
REQ-033 Valid pattern of 1 cycle on, 2 off, with the same data as REQ-031 -> identical output sequence, each data_valid_out pulse exactly 3 cycles after its input.
REQ-034 Row start: hcount 0 column A, then hcount 1 column B -> the first output equals the kernel applied to window A,A,A; the second to window A,A,B.
REQ-035 rst_in pulsed 1 cycle after a valid input -> data_valid_out=0 for all following cycles until new valid input; outputs read 0.

Source files
------------

// File: rtl/convolution.sv
// 3x3 RGB565 convolution: window register, weighted-sum register, then a clamp/pack output register.
// The kernel is fixed at elaboration by K_SELECT (0 identity, 1 Gaussian, 2 sharpen, other values identity).
module convolution #(
    parameter int K_SELECT = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [2:0][15:0] data_in,
    input  logic             data_valid_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    output logic [15:0]      line_out,
    output logic             data_valid_out,
    output logic [10:0]      hcount_out,
    output logic [9:0]       vcount_out
);

    typedef logic [2:0][15:0] column_t;
    typedef logic signed [11:0] sum_t;

    column_t     col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;
    logic        valid1_q, valid1_d, valid2_q, valid2_d, valid3_q, valid3_d;
    logic [10:0] hcount1_q, hcount1_d, hcount2_q, hcount2_d, hcount3_q, hcount3_d;
    logic [9:0]  vcount1_q, vcount1_d, vcount2_q, vcount2_d, vcount3_q, vcount3_d;
    sum_t        sum_q [3];
    sum_t        sum_d [3];
    logic [15:0] line_q, line_d;
    column_t     window [3];
    sum_t        acc;

    // Weight for row r (0 top) of column c (0 oldest).
    function automatic logic signed [3:0] weight(input int unsigned r, input int unsigned c);
        logic centre;
        logic corner;
        logic signed [3:0] w;
        centre = (r == 1) && (c == 1);
        corner = (r != 1) && (c != 1);
        case (K_SELECT)
            1:       w = centre ? 4'sd4 : (corner ? 4'sd1 : 4'sd2);
            2:       w = centre ? 4'sd5 : (corner ? 4'sd0 : -4'sd1);
            default: w = centre ? 4'sd1 : 4'sd0;
        endcase
        return w;
    endfunction

    function automatic sum_t pixel_channel(input logic [15:0] px, input int unsigned ch);
        logic [11:0] v;
        case (ch)
            0:       v = {7'd0, px[15:11]};
            1:       v = {6'd0, px[10:5]};
            default: v = {7'd0, px[4:0]};
        endcase
        return $signed(v);
    endfunction

    function automatic logic [5:0] clamp_channel(input sum_t s, input logic [5:0] max_val);
        sum_t v;
        v = (K_SELECT == 1) ? sum_t'(s >> 4) : s;
        if (v[11]) begin
            return '0;
        end
        if (v > $signed({6'd0, max_val})) begin
            return max_val;
        end
        return v[5:0];
    endfunction

    always_comb begin
        col0_d = col0_q;
        col1_d = col1_q;
        col2_d = col2_q;
        if (data_valid_in) begin
            if (hcount_in == '0) begin
                col0_d = data_in;
                col1_d = data_in;
                col2_d = data_in;
            end else begin
                col0_d = col1_q;
                col1_d = col2_q;
                col2_d = data_in;
            end
        end

        valid1_d  = data_valid_in;
        hcount1_d = data_valid_in ? hcount_in : hcount1_q;
        vcount1_d = data_valid_in ? vcount_in : vcount1_q;
        valid2_d  = valid1_q;
        hcount2_d = valid1_q ? hcount1_q : hcount2_q;
        vcount2_d = valid1_q ? vcount1_q : vcount2_q;
        valid3_d  = valid2_q;
        hcount3_d = valid2_q ? hcount2_q : hcount3_q;
        vcount3_d = valid2_q ? vcount2_q : vcount3_q;

        window[0] = col0_q;
        window[1] = col1_q;
        window[2] = col2_q;
        acc = '0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            acc = '0;
            for (int unsigned c = 0; c < 3; c++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    acc = acc + sum_t'(weight(r, c)) * pixel_channel(window[c][r], ch);
                end
            end
            sum_d[ch] = valid1_q ? acc : sum_q[ch];
        end

        line_d = line_q;
        if (valid2_q) begin
            line_d = {5'(clamp_channel(sum_q[0], 6'd31)),
                      clamp_channel(sum_q[1], 6'd63),
                      5'(clamp_channel(sum_q[2], 6'd31))};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            col0_q    <= '0;
            col1_q    <= '0;
            col2_q    <= '0;
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            valid3_q  <= 1'b0;
            hcount1_q <= '0;
            hcount2_q <= '0;
            hcount3_q <= '0;
            vcount1_q <= '0;
            vcount2_q <= '0;
            vcount3_q <= '0;
            sum_q     <= '{default: '0};
            line_q    <= '0;
        end else begin
            col0_q    <= col0_d;
            col1_q    <= col1_d;
            col2_q    <= col2_d;
            valid1_q  <= valid1_d;
            valid2_q  <= valid2_d;
            valid3_q  <= valid3_d;
            hcount1_q <= hcount1_d;
            hcount2_q <= hcount2_d;
            hcount3_q <= hcount3_d;
            vcount1_q <= vcount1_d;
            vcount2_q <= vcount2_d;
            vcount3_q <= vcount3_d;
            sum_q     <= sum_d;
            line_q    <= line_d;
        end
    end

    assign line_out       = line_q;
    assign data_valid_out = valid3_q;
    assign hcount_out     = hcount3_q;
    assign vcount_out     = vcount3_q;

endmodule

// File: tb/tb_convolution.sv
// Directed bench for convolution: identity, Gaussian and sharpen instances share one input stream.
module tb_convolution;

    logic             clk;
    logic             rst;
    logic [2:0][15:0] din;
    logic             dvin;
    logic [10:0]      hin;
    logic [9:0]       vin;

    logic [15:0] line0, line1, line2;
    logic        dv0, dv1, dv2;
    logic [10:0] h0, h1, h2;
    logic [9:0]  v0, v1, v2;

    int checks;
    int failures;

    convolution #(.K_SELECT(0)) u_id (
        .clk_in(clk), .rst_in(rst), .data_in(din), .data_valid_in(dvin),
        .hcount_in(hin), .vcount_in(vin), .line_out(line0), .data_valid_out(dv0),
        .hcount_out(h0), .vcount_out(v0)
    );
    convolution #(.K_SELECT(1)) u_gs (
        .clk_in(clk), .rst_in(rst), .data_in(din), .data_valid_in(dvin),
        .hcount_in(hin), .vcount_in(vin), .line_out(line1), .data_valid_out(dv1),
        .hcount_out(h1), .vcount_out(v1)
    );
    convolution #(.K_SELECT(2)) u_sh (
        .clk_in(clk), .rst_in(rst), .data_in(din), .data_valid_in(dvin),
        .hcount_in(hin), .vcount_in(vin), .line_out(line2), .data_valid_out(dv2),
        .hcount_out(h2), .vcount_out(v2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] h, input logic [9:0] v,
                         input logic [15:0] top, input logic [15:0] mid, input logic [15:0] bot);
        dvin   = 1'b1;
        hin    = h;
        vin    = v;
        din[0] = top;
        din[1] = mid;
        din[2] = bot;
    endtask

    task automatic idle();
        dvin = 1'b0;
        hin  = 11'h5A5;
        vin  = 10'h2A5;
        din  = {16'hDEAD, 16'hBEEF, 16'hCAFE};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] px(input int c);
        return 16'(16'h0841 * (c + 1));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks += 12;
        if (line0 !== 16'h0) begin failures++; $display("FAIL reset_line_k0 got %h want 0000", line0); end
        if (line1 !== 16'h0) begin failures++; $display("FAIL reset_line_k1 got %h want 0000", line1); end
        if (line2 !== 16'h0) begin failures++; $display("FAIL reset_line_k2 got %h want 0000", line2); end
        if (dv0 !== 1'b0) begin failures++; $display("FAIL reset_valid_k0 got %b want 0", dv0); end
        if (dv1 !== 1'b0) begin failures++; $display("FAIL reset_valid_k1 got %b want 0", dv1); end
        if (dv2 !== 1'b0) begin failures++; $display("FAIL reset_valid_k2 got %b want 0", dv2); end
        if (h0 !== 11'h0) begin failures++; $display("FAIL reset_h_k0 got %h want 0", h0); end
        if (h1 !== 11'h0) begin failures++; $display("FAIL reset_h_k1 got %h want 0", h1); end
        if (h2 !== 11'h0) begin failures++; $display("FAIL reset_h_k2 got %h want 0", h2); end
        if (v0 !== 10'h0) begin failures++; $display("FAIL reset_v_k0 got %h want 0", v0); end
        if (v1 !== 10'h0) begin failures++; $display("FAIL reset_v_k1 got %h want 0", v1); end
        if (v2 !== 10'h0) begin failures++; $display("FAIL reset_v_k2 got %h want 0", v2); end
        rst = 1'b0;
    endtask

    // Flat 0ABC frame: every kernel has unit gain, so all outputs stay 0ABC.
    task automatic test_gauss_const();
        int n_out;
        int s;
        logic exp_v;
        n_out = 0;
        do_reset();
        for (int t = 0; t < 103; t++) begin
            if (t < 100) drive(11'(t % 10), 10'(t / 10), 16'h0ABC, 16'h0ABC, 16'h0ABC);
            else idle();
            tick();
            s = t - 2;
            exp_v = (s >= 0) && (s < 100);
            checks++;
            if (dv1 !== exp_v) begin failures++; $display("FAIL const_valid t=%0d got %b want %b", t, dv1, exp_v); end
            if (dv1 === 1'b1) n_out++;
            if (exp_v) begin
                checks += 5;
                if (line0 !== 16'h0ABC) begin failures++; $display("FAIL const_k0 t=%0d got %h want 0abc", t, line0); end
                if (line1 !== 16'h0ABC) begin failures++; $display("FAIL const_k1 t=%0d got %h want 0abc", t, line1); end
                if (line2 !== 16'h0ABC) begin failures++; $display("FAIL const_k2 t=%0d got %h want 0abc", t, line2); end
                if (h1 !== 11'(s % 10)) begin failures++; $display("FAIL const_h t=%0d got %0d want %0d", t, h1, s % 10); end
                if (v1 !== 10'(s / 10)) begin failures++; $display("FAIL const_v t=%0d got %0d want %0d", t, v1, s / 10); end
            end
        end
        checks++;
        if (n_out !== 100) begin failures++; $display("FAIL const_count got %0d want 100", n_out); end
    endtask

    // Identity on a ramp; gap idle cycles follow each valid column.
    task automatic test_identity_stream(input int gap);
        int at_col [64];
        int total;
        int s;
        int c;
        logic [15:0] last;
        logic [15:0] exp_line;
        do_reset();
        last  = 16'h0;
        total = 8 * (gap + 1) + 3;
        for (int t = 0; t < total; t++) begin
            if ((t % (gap + 1) == 0) && (t / (gap + 1) < 8)) begin
                at_col[t] = t / (gap + 1);
                drive(11'(at_col[t]), 10'd5, ~px(at_col[t]), px(at_col[t]), px(at_col[t]) ^ 16'h5555);
            end else begin
                at_col[t] = -1;
                idle();
            end
            tick();
            s = t - 2;
            c = (s >= 0) ? at_col[s] : -1;
            checks++;
            if (dv0 !== (c >= 0)) begin failures++; $display("FAIL ident_valid gap=%0d t=%0d got %b want %b", gap, t, dv0, c >= 0); end
            if (c >= 0) begin
                exp_line = px((c == 0) ? 0 : c - 1);
                last = exp_line;
                checks += 3;
                if (line0 !== exp_line) begin failures++; $display("FAIL ident_line gap=%0d t=%0d got %h want %h", gap, t, line0, exp_line); end
                if (h0 !== 11'(c)) begin failures++; $display("FAIL ident_h gap=%0d t=%0d got %0d want %0d", gap, t, h0, c); end
                if (v0 !== 10'd5) begin failures++; $display("FAIL ident_v gap=%0d t=%0d got %0d want 5", gap, t, v0); end
            end else begin
                checks++;
                if (line0 !== last) begin failures++; $display("FAIL ident_hold gap=%0d t=%0d got %h want %h", gap, t, line0, last); end
            end
        end
    endtask

    task automatic test_sharpen_clamp();
        // Lone bright centre pixel.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            if (t == 0) drive(11'd0, 10'd0, 16'h0000, 16'h0000, 16'h0000);
            else if (t == 1) drive(11'd1, 10'd0, 16'h0000, 16'hFFFF, 16'h0000);
            else if (t == 2) drive(11'd2, 10'd0, 16'h0000, 16'h0000, 16'h0000);
            else idle();
            tick();
        end
        checks += 4;
        if (dv2 !== 1'b1) begin failures++; $display("FAIL clamp_hi_valid got %b want 1", dv2); end
        if (line2 !== 16'hFFFF) begin failures++; $display("FAIL clamp_hi_k2 got %h want ffff", line2); end
        if (line1 !== 16'h39E7) begin failures++; $display("FAIL clamp_hi_k1 got %h want 39e7", line1); end
        if (line0 !== 16'hFFFF) begin failures++; $display("FAIL clamp_hi_k0 got %h want ffff", line0); end
        // Dark centre with bright orthogonal neighbours.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            if (t == 0) drive(11'd0, 10'd0, 16'h0000, 16'hFFFF, 16'h0000);
            else if (t == 1) drive(11'd1, 10'd0, 16'hFFFF, 16'h0000, 16'hFFFF);
            else if (t == 2) drive(11'd2, 10'd0, 16'h0000, 16'hFFFF, 16'h0000);
            else idle();
            tick();
        end
        checks += 3;
        if (line2 !== 16'h0000) begin failures++; $display("FAIL clamp_lo_k2 got %h want 0000", line2); end
        if (line1 !== 16'h7BEF) begin failures++; $display("FAIL clamp_lo_k1 got %h want 7bef", line1); end
        if (line0 !== 16'h0000) begin failures++; $display("FAIL clamp_lo_k0 got %h want 0000", line0); end
    endtask

    task automatic test_row_start();
        do_reset();
        drive(11'd0, 10'd7, 16'h0800, 16'h1000, 16'h1800);
        tick();
        drive(11'd1, 10'd7, 16'h001F, 16'h001F, 16'h001F);
        tick();
        idle();
        tick();
        checks += 5;
        if (line0 !== 16'h1000) begin failures++; $display("FAIL row_aaa_k0 got %h want 1000", line0); end
        if (line1 !== 16'h1000) begin failures++; $display("FAIL row_aaa_k1 got %h want 1000", line1); end
        if (line2 !== 16'h1000) begin failures++; $display("FAIL row_aaa_k2 got %h want 1000", line2); end
        if (h1 !== 11'd0) begin failures++; $display("FAIL row_aaa_h got %0d want 0", h1); end
        if (dv1 !== 1'b1) begin failures++; $display("FAIL row_aaa_valid got %b want 1", dv1); end
        tick();
        checks += 5;
        if (line0 !== 16'h1000) begin failures++; $display("FAIL row_aab_k0 got %h want 1000", line0); end
        if (line1 !== 16'h0807) begin failures++; $display("FAIL row_aab_k1 got %h want 0807", line1); end
        if (line2 !== 16'h2000) begin failures++; $display("FAIL row_aab_k2 got %h want 2000", line2); end
        if (h1 !== 11'd1) begin failures++; $display("FAIL row_aab_h got %0d want 1", h1); end
        if (v1 !== 10'd7) begin failures++; $display("FAIL row_aab_v got %0d want 7", v1); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        drive(11'd3, 10'd4, 16'h1234, 16'h5678, 16'h9ABC);
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            checks += 6;
            if (dv0 !== 1'b0) begin failures++; $display("FAIL midrst_valid_k0 t=%0d got %b want 0", t, dv0); end
            if (dv1 !== 1'b0) begin failures++; $display("FAIL midrst_valid_k1 t=%0d got %b want 0", t, dv1); end
            if (dv2 !== 1'b0) begin failures++; $display("FAIL midrst_valid_k2 t=%0d got %b want 0", t, dv2); end
            if (line1 !== 16'h0) begin failures++; $display("FAIL midrst_line t=%0d got %h want 0000", t, line1); end
            if (h1 !== 11'h0) begin failures++; $display("FAIL midrst_h t=%0d got %0d want 0", t, h1); end
            if (v1 !== 10'h0) begin failures++; $display("FAIL midrst_v t=%0d got %0d want 0", t, v1); end
        end
        drive(11'd0, 10'd1, 16'h0ABC, 16'h0ABC, 16'h0ABC);
        tick();
        idle();
        checks++;
        if (dv1 !== 1'b0) begin failures++; $display("FAIL post_rst_early1 got %b want 0", dv1); end
        tick();
        checks++;
        if (dv1 !== 1'b0) begin failures++; $display("FAIL post_rst_early2 got %b want 0", dv1); end
        tick();
        checks += 4;
        if (dv1 !== 1'b1) begin failures++; $display("FAIL post_rst_valid got %b want 1", dv1); end
        if (line1 !== 16'h0ABC) begin failures++; $display("FAIL post_rst_line got %h want 0abc", line1); end
        if (h1 !== 11'd0) begin failures++; $display("FAIL post_rst_h got %0d want 0", h1); end
        if (v1 !== 10'd1) begin failures++; $display("FAIL post_rst_v got %0d want 1", v1); end
        tick();
        checks++;
        if (dv1 !== 1'b0) begin failures++; $display("FAIL post_rst_single got %b want 0", dv1); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        test_reset();
        test_gauss_const();
        test_identity_stream(0);
        test_identity_stream(2);
        test_sharpen_clamp();
        test_row_start();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
